spi_sram: RTL and testbench

SPI_SRAM -- requirements
Module: spi_sram

---
 rtl/spi_sram_pkg.sv | 30 +++
 rtl/sram_array.sv | 26 ++
 rtl/spi_sram.sv | 184 ++++++++++++++++++
 tb/tb_spi_sram.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// rtl/spi_sram_pkg.sv - opcodes, mode encodings and FSM states shared by the SPI SRAM slave
package spi_sram_pkg;

    localparam logic [7:0] OP_WRSR  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;
    localparam logic [7:0] OP_READ  = 8'h03;
    localparam logic [7:0] OP_RDSR  = 8'h05;

    localparam logic [1:0] MODE_BYTE     = 2'b00;
    localparam logic [1:0] MODE_SEQ      = 2'b01;
    localparam logic [1:0] MODE_PAGE     = 2'b10;
    localparam logic [1:0] MODE_BYTE_ALT = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        RD_DATA,
        WR_DATA,
        RD_SR,
        WR_SR,
        IGNORE
    } state_t;

    // Both 00 and 11 transfer a single data byte per transaction.
    function automatic logic is_byte_mode(input logic [1:0] m);
        return (m == MODE_BYTE) || (m == MODE_BYTE_ALT);
    endfunction

endpackage

// File: rtl/sram_array.sv
// rtl/sram_array.sv - byte-wide storage with synchronous write and registered 1-cycle read
module sram_array #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    // Contents deliberately have no reset so they survive rst_n.
    logic [7:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/spi_sram.sv
// rtl/spi_sram.sv - SPI mode-0 serial SRAM slave: front end, FSM and address generator
module spi_sram
    import spi_sram_pkg::*;
#(
    parameter int ADDR_W     = 13,
    parameter int PAGE_BYTES = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sck,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [1:0] mode
);

    // Shift register only keeps the bits an opcode or the retained address needs.
    localparam int SH_W = (ADDR_W > 8) ? ADDR_W - 1 : 7;
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'(PAGE_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

    state_t state, state_n;

    logic [1:0]        sck_sync, cs_sync, mosi_sync;
    logic              sck_d, cs_d;
    logic              sck_rise, sck_fall, cs_fall, cs_hi, mosi_b;
    logic [3:0]        bit_cnt;
    logic [SH_W-1:0]   shreg;
    logic [7:0]        rx_byte, tx_byte, load_byte, rd_data;
    logic [ADDR_W-1:0] addr, addr_next;
    logic [1:0]        mode_r;
    logic              rd_op, fetch, miso_r, byte_end, wr_en;

    // cs_n chain resets low so a select already held at reset release is not taken as a fall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_sync  <= 2'b00;
            cs_sync   <= 2'b00;
            mosi_sync <= 2'b00;
            sck_d     <= 1'b0;
            cs_d      <= 1'b0;
        end else begin
            sck_sync  <= {sck_sync[0], sck};
            cs_sync   <= {cs_sync[0], cs_n};
            mosi_sync <= {mosi_sync[0], mosi};
            sck_d     <= sck_sync[1];
            cs_d      <= cs_sync[1];
        end
    end

    assign sck_rise = sck_sync[1] & ~sck_d;
    assign sck_fall = ~sck_sync[1] & sck_d;
    assign cs_fall  = cs_d & ~cs_sync[1];
    assign cs_hi    = cs_sync[1];
    assign mosi_b   = mosi_sync[1];

    assign rx_byte   = {shreg[6:0], mosi_b};
    assign byte_end  = (bit_cnt == 4'd7);
    assign load_byte = (state == RD_SR) ? {mode_r, 6'b0} : rd_data;
    assign addr_next = (mode_r == MODE_PAGE)
                     ? ((addr & ~PAGE_MASK) | ((addr + ADDR_ONE) & PAGE_MASK))
                     : addr + ADDR_ONE;
    assign wr_en     = (state == WR_DATA) && sck_rise && byte_end && !cs_hi;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        if (cs_hi && state != IDLE) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (cs_fall) state_n = CMD;
                CMD: begin
                    if (sck_rise && byte_end) begin
                        case (rx_byte)
                            OP_READ, OP_WRITE: state_n = ADDR;
                            OP_RDSR:           state_n = RD_SR;
                            OP_WRSR:           state_n = WR_SR;
                            default:           state_n = IGNORE;
                        endcase
                    end
                end
                ADDR: begin
                    if (sck_rise && bit_cnt == 4'd15) begin
                        state_n = rd_op ? RD_DATA : WR_DATA;
                    end
                end
                RD_DATA, WR_DATA: begin
                    if (sck_rise && byte_end && is_byte_mode(mode_r)) state_n = IGNORE;
                end
                WR_SR: if (sck_rise && byte_end) state_n = IGNORE;
                default: state_n = state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= 4'd0;
            shreg   <= '0;
            tx_byte <= 8'h00;
            addr    <= '0;
            mode_r  <= MODE_BYTE;
            rd_op   <= 1'b0;
            fetch   <= 1'b0;
            miso_r  <= 1'b0;
        end else begin
            fetch <= 1'b0;
            if (cs_hi || state == IDLE) begin
                bit_cnt <= 4'd0;
                miso_r  <= 1'b0;
            end else begin
                case (state)
                    CMD, ADDR, WR_DATA, WR_SR: begin
                        if (sck_rise) begin
                            shreg   <= {shreg[SH_W-2:0], mosi_b};
                            bit_cnt <= bit_cnt + 4'd1;
                            if (state == CMD && byte_end) begin
                                bit_cnt <= 4'd0;
                                rd_op   <= (rx_byte == OP_READ);
                            end
                            if (state == ADDR && bit_cnt == 4'd15) begin
                                addr  <= {shreg[ADDR_W-2:0], mosi_b};
                                fetch <= 1'b1;
                            end
                            if (state == WR_DATA && byte_end) begin
                                bit_cnt <= 4'd0;
                                addr    <= addr_next;
                            end
                            if (state == WR_SR && byte_end) begin
                                mode_r <= rx_byte[7:6];
                            end
                        end
                    end
                    RD_DATA, RD_SR: begin
                        // The fall preceding each byte's first rise loads a fresh byte.
                        if (sck_fall) begin
                            if (bit_cnt == 4'd0) begin
                                miso_r  <= load_byte[7];
                                tx_byte <= {load_byte[6:0], 1'b0};
                            end else begin
                                miso_r  <= tx_byte[7];
                                tx_byte <= {tx_byte[6:0], 1'b0};
                            end
                        end
                        if (sck_rise) begin
                            bit_cnt <= byte_end ? 4'd0 : bit_cnt + 4'd1;
                            if (state == RD_DATA && byte_end) begin
                                addr  <= addr_next;
                                fetch <= 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    sram_array #(
        .ADDR_W(ADDR_W)
    ) u_array (
        .clk    (clk),
        .wr_en  (wr_en),
        .wr_addr(addr),
        .wr_data(rx_byte),
        .rd_en  (fetch),
        .rd_addr(addr),
        .rd_data(rd_data)
    );

    assign miso_oe = ((state == RD_DATA) || (state == RD_SR)) && !cs_hi;
    assign miso    = miso_r & miso_oe;
    assign mode    = mode_r;

endmodule

// File: tb/tb_spi_sram.sv
// tb/tb_spi_sram.sv - SPI master driver with transaction-level memory/mode model of the SRAM slave
module tb_spi_sram;

    localparam int ADDR_W     = 13;
    localparam int PAGE_BYTES = 32;
    localparam int DEPTH      = 1 << ADDR_W;
    localparam int HALF       = 60;

    logic       clk = 1'b0;
    logic       rst_n, sck, cs_n, mosi;
    logic       miso, miso_oe;
    logic [1:0] mode;

    spi_sram #(
        .ADDR_W    (ADDR_W),
        .PAGE_BYTES(PAGE_BYTES)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .sck    (sck),
        .cs_n   (cs_n),
        .mosi   (mosi),
        .miso   (miso),
        .miso_oe(miso_oe),
        .mode   (mode)
    );

    always #5 clk = ~clk;

    logic [7:0] mdl_mem   [DEPTH];
    bit         mdl_known [DEPTH];
    logic [1:0] mdl_mode;
    logic       exp_oe, exp_miso, exp_chk;
    logic [7:0] tx_buf [8];
    logic [7:0] rx_buf [8];
    int         n_cmp, n_bad;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic bit byte_mode();
        return (mdl_mode == 2'b00) || (mdl_mode == 2'b11);
    endfunction

    function automatic int addr_of(input int a, input int k);
        if (mdl_mode == 2'b10) return (a / PAGE_BYTES) * PAGE_BYTES + (a + k) % PAGE_BYTES;
        if (mdl_mode == 2'b01) return (a + k) % DEPTH;
        return a;
    endfunction

    // Master samples at each sck rise; that is where miso must be stable.
    always @(posedge sck) begin
        if (!cs_n && rst_n) begin
            check("miso_oe", miso_oe, exp_oe);
            if (exp_oe && exp_chk) check("miso", miso, exp_miso);
            else if (!exp_oe) check("miso_idle", miso, 1'b0);
            check("mode", mode, mdl_mode);
        end
    end

    task automatic txn(input logic [7:0] op, input int a, input int dbits, input int rst_bit);
        int         hdr, total, j, k, ad, am;
        logic [15:0] a16;
        logic [7:0]  sr_byte;
        a16   = a[15:0];
        am    = a % DEPTH;
        hdr   = (op == 8'h03 || op == 8'h02) ? 24 : 8;
        total = hdr + dbits;
        for (int m = 0; m < 8; m++) rx_buf[m] = 8'h00;
        cs_n = 1'b0;
        for (int i = 0; i < total; i++) begin
            j = i - hdr;
            k = j / 8;
            if (i < 8) mosi = op[7 - i];
            else if (i < hdr) mosi = a16[15 - (i - 8)];
            else mosi = tx_buf[k][7 - j % 8];
            exp_oe = 1'b0; exp_chk = 1'b0; exp_miso = 1'b0;
            if (i >= hdr) begin
                if (op == 8'h03 && !(byte_mode() && k > 0)) begin
                    ad       = addr_of(am, k);
                    exp_oe   = 1'b1;
                    exp_chk  = mdl_known[ad];
                    exp_miso = mdl_mem[ad][7 - j % 8];
                end else if (op == 8'h05) begin
                    sr_byte  = {mdl_mode, 6'b0};
                    exp_oe   = 1'b1;
                    exp_chk  = 1'b1;
                    exp_miso = sr_byte[7 - j % 8];
                end
            end
            #HALF;
            if (i >= hdr && k < 8) rx_buf[k][7 - j % 8] = miso;
            sck = 1'b1;
            #HALF;
            if (i == rst_bit) begin
                rst_n = 1'b0;
                #1;
                check("rst_miso_oe", miso_oe, 1'b0);
                check("rst_mode", mode, 2'b00);
                mdl_mode = 2'b00;
                sck  = 1'b0;
                cs_n = 1'b1;
                #(4*HALF - 1);
                rst_n = 1'b1;
                #(2*HALF);
                return;
            end
            if (i >= hdr && j % 8 == 7) begin
                if (op == 8'h02 && !(byte_mode() && k > 0)) begin
                    ad = addr_of(am, k);
                    mdl_mem[ad]   = tx_buf[k];
                    mdl_known[ad] = 1'b1;
                end
                if (op == 8'h01 && k == 0) mdl_mode = tx_buf[0][7:6];
            end
            sck = 1'b0;
        end
        #HALF;
        cs_n = 1'b1;
        #(2*HALF);
        check("idle_miso_oe", miso_oe, 1'b0);
        check("idle_miso", miso, 1'b0);
        check("idle_mode", mode, mdl_mode);
    endtask

    int         r, a, nb, last_a;
    logic [7:0] op;

    initial begin
        rst_n = 1'b0; sck = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        exp_oe = 1'b0; exp_chk = 1'b0; exp_miso = 1'b0;
        mdl_mode = 2'b00; n_cmp = 0; n_bad = 0; last_a = 0;
        #23;
        check("reset_miso_oe", miso_oe, 1'b0);
        check("reset_miso", miso, 1'b0);
        check("reset_mode", mode, 2'b00);
        rst_n = 1'b1;
        #(2*HALF);

        // Byte mode write/read; second read byte must leave the pad undriven.
        tx_buf[0] = 8'h01; txn(8'h02, 16'h0001, 8, -1);
        txn(8'h03, 16'h0001, 16, -1);
        check("rd_0001", rx_buf[0], 8'h01);

        tx_buf[0] = 8'h40; txn(8'h01, 0, 8, -1);
        check("mode_seq", mode, 2'b01);
        txn(8'h05, 0, 16, -1);
        check("rdsr_b0", rx_buf[0], 8'h40);
        check("rdsr_b1", rx_buf[1], 8'h40);

        // Sequential wrap across the top of memory.
        tx_buf[0] = 8'h0F; tx_buf[1] = 8'hF0; tx_buf[2] = 8'hAA;
        txn(8'h02, 16'h1FFF, 24, -1);
        txn(8'h03, 16'h1FFF, 24, -1);
        check("seq_rd0", rx_buf[0], 8'h0F);
        check("seq_rd1", rx_buf[1], 8'hF0);
        check("seq_rd2", rx_buf[2], 8'hAA);
        txn(8'h03, 16'h0000, 8, -1);
        check("seq_at_0000", rx_buf[0], 8'hF0);
        txn(8'h03, 16'h0001, 8, -1);
        check("seq_at_0001", rx_buf[0], 8'hAA);

        // Page mode wraps inside the 32-byte page.
        tx_buf[0] = 8'h5A; txn(8'h02, 16'h0040, 8, -1);
        tx_buf[0] = 8'h80; txn(8'h01, 0, 8, -1);
        check("mode_page", mode, 2'b10);
        tx_buf[0] = 8'h11; tx_buf[1] = 8'h22;
        txn(8'h02, 16'h003F, 16, -1);
        txn(8'h03, 16'h0020, 8, -1);
        check("page_at_0020", rx_buf[0], 8'h22);
        txn(8'h03, 16'h0040, 8, -1);
        check("page_at_0040", rx_buf[0], 8'h5A);
        txn(8'h03, 16'h003F, 8, -1);
        check("page_at_003F", rx_buf[0], 8'h11);

        // Aborted partial write and unknown opcode.
        tx_buf[0] = 8'h00; txn(8'h01, 0, 8, -1);
        tx_buf[0] = 8'h77; txn(8'h02, 16'h0005, 8, -1);
        tx_buf[0] = 8'h00; txn(8'h02, 16'h0005, 5, -1);
        txn(8'h03, 16'h0005, 8, -1);
        check("abort_keeps", rx_buf[0], 8'h77);
        tx_buf[0] = 8'h3C; tx_buf[1] = 8'hC3;
        txn(8'hAB, 0, 16, -1);

        // Reset in the middle of a read data byte.
        tx_buf[0] = 8'h40; txn(8'h01, 0, 8, -1);
        txn(8'h03, 16'h0005, 8, 24 + 3);
        txn(8'h03, 16'h0005, 8, -1);
        check("after_rst_rd", rx_buf[0], 8'h77);
        check("after_rst_mode", mode, 2'b00);

        for (int n = 0; n < 40; n++) begin
            r  = $urandom_range(0, 9);
            nb = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
                0:       a = $urandom_range(0, 65535);
                1:       a = last_a;
                default: a = (DEPTH - 1 - $urandom_range(0, 2)) + DEPTH * $urandom_range(0, 7);
            endcase
            for (int m = 0; m < 8; m++) tx_buf[m] = 8'($urandom);
            case (r)
                0, 1, 2: begin txn(8'h02, a, nb * 8, -1); last_a = a; end
                3, 4, 5: txn(8'h03, a, nb * 8, -1);
                6:       txn(8'h05, 0, nb * 8, -1);
                7:       txn(8'h01, 0, (nb == 4) ? 5 : 8 * ((nb + 1) / 2), -1);
                8: begin
                    op = 8'($urandom);
                    if (op == 8'h01 || op == 8'h02 || op == 8'h03 || op == 8'h05) op = 8'hFF;
                    txn(op, a, nb * 8, -1);
                end
                default: txn(8'h02, a, $urandom_range(1, 7) + 8 * $urandom_range(0, 2), -1);
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
